// File: rtl/cadder_result_checker.sv
// In-fabric scoreboard for the cadder twin: delays golden A+B by LATENCY and checks DUT Z against it.
// Latency: results registered, visible one cycle after each compare; FILL waits LATENCY cycles first.
// Backpressure: none, samples every cycle in RUN. CADDER_CHECKER_BITHIST_EN adds per-bit error counters.
module cadder_result_checker #(
  parameter int DW      = 4,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             wave_clk,
  input  logic             wave_rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_samp,
  input  logic [DW-1:0]    A,
  input  logic [DW-1:0]    B,
  input  logic [DW:0]      Z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [DW:0]      first_err_exp,
  output logic [DW:0]      first_err_got
`ifdef CADDER_CHECKER_BITHIST_EN
  ,
  output logic [(DW+1)*CNT_W-1:0] bit_err_hist
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       FILL_LAST = 4'(LATENCY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] samp_inc;
  logic [3:0]       fill_cnt;
  logic [DW:0]      exp0, exp_d;
  logic             accept, mismatch, in_run;

  assign exp0 = {1'b0, A} + {1'b0, B};

  // Delay line shifts unconditionally so it is already primed when FILL ends.
  generate
    if (LATENCY == 0) begin : g_nodly
      assign exp_d = exp0;
    end else begin : g_dly
      logic [DW:0] dly [LATENCY];
      always_ff @(posedge wave_clk or posedge wave_rst) begin
        if (wave_rst) begin
          for (int i = 0; i < LATENCY; i++) dly[i] <= '0;
        end else begin
          dly[0] <= exp0;
          for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
        end
      end
      assign exp_d = dly[LATENCY-1];
    end
  endgenerate

  assign accept   = ((state == IDLE) || (state == DONE)) && start;
  assign in_run   = (state == RUN);
  assign mismatch = (Z != exp_d);
  assign samp_inc = sample_count + CNT_ONE;

  always_ff @(posedge wave_clk or posedge wave_rst) begin
    if (wave_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (num_samp == '0)  state_nxt = DONE;
          else if (LATENCY > 0) state_nxt = FILL;
          else                  state_nxt = RUN;
        end
      end
      FILL: begin
        if (stop)                       state_nxt = DONE;
        else if (fill_cnt == FILL_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (stop || (samp_inc == num_lat)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wave_clk or posedge wave_rst) begin
    if (wave_rst) begin
      fill_cnt      <= '0;
      num_lat       <= '0;
      sample_count  <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      fill_cnt <= (state == FILL) ? fill_cnt + 4'd1 : 4'd0;
      if (accept) begin
        num_lat       <= num_samp;
        sample_count  <= '0;
        err_count     <= '0;
        first_err_idx <= '0;
        first_err_exp <= '0;
        first_err_got <= '0;
      end else if (in_run) begin
        sample_count <= samp_inc;
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + CNT_ONE;
          if (err_count == '0) begin
            first_err_idx <= sample_count;
            first_err_exp <= exp_d;
            first_err_got <= Z;
          end
        end
      end
    end
  end

`ifdef CADDER_CHECKER_BITHIST_EN
  logic [CNT_W-1:0] hist [DW+1];
  logic [DW:0]      bit_diff;

  assign bit_diff = Z ^ exp_d;

  always_ff @(posedge wave_clk or posedge wave_rst) begin
    if (wave_rst) begin
      for (int i = 0; i <= DW; i++) hist[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i <= DW; i++) hist[i] <= '0;
    end else if (in_run) begin
      for (int i = 0; i <= DW; i++)
        if (bit_diff[i] && (hist[i] != '1)) hist[i] <= hist[i] + CNT_ONE;
    end
  end

  for (genvar g = 0; g <= DW; g++) begin : g_hist
    assign bit_err_hist[g*CNT_W +: CNT_W] = hist[g];
  end
`endif

  assign busy = (state == FILL) || (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule
